// File: rtl/regtrace_ascii_tx.sv
// Register-writeback trace serializer: buffers (addr, data) events and emits each one
// as an ASCII line "nn=hhhh..\n", one byte per valid/ready handshake.
module regtrace_ascii_tx #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int NAME_MODE  = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              tx_valid,
    output logic [7:0]        tx_byte,
    input  logic              tx_ready,
    output logic              fifo_full,
    output logic [15:0]       drop_cnt,
    output logic              busy
);

    localparam int NH = DATA_W / 4;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(NH) + 1;

    typedef enum logic [2:0] {IDLE, LOAD, NAME, EQ, HEX, EOL} state_t;

    state_t            state, next_state;
    logic [4:0]        fa [FIFO_DEPTH];
    logic [DATA_W-1:0] fd [FIFO_DEPTH];
    logic [AW:0]       wp, rp;
    logic              empty, full, push, drop, pop, accept;
    logic [4:0]        line_addr;
    logic [DATA_W-1:0] hex_sr;
    logic [15:0]       name_r;
    logic [CW-1:0]     idx;

    function automatic logic [7:0] hex_char(input logic [3:0] v);
        return (v < 4'd10) ? 8'h30 + {4'h0, v} : 8'h57 + {4'h0, v};
    endfunction

    function automatic logic [15:0] name_of(input logic [4:0] a);
        logic [7:0] n;
        n = {3'b000, a};
        if (NAME_MODE == 0)  return {hex_char({3'b000, a[4]}), hex_char(a[3:0])};
        if (a == 5'd0)       return "zr";
        if (a == 5'd1)       return "at";
        if (a <= 5'd3)       return {"v", "0" + n - 8'd2};
        if (a <= 5'd7)       return {"a", "0" + n - 8'd4};
        if (a <= 5'd15)      return {"t", "0" + n - 8'd8};
        if (a <= 5'd23)      return {"s", "0" + n - 8'd16};
        if (a <= 5'd25)      return {"t", "0" + n - 8'd16};
        if (a <= 5'd27)      return {"k", "0" + n - 8'd26};
        if (a == 5'd28)      return "gp";
        if (a == 5'd29)      return "sp";
        if (a == 5'd30)      return "fp";
        return "ra";
    endfunction

    // Full is judged before any same-edge pop, so a push onto a full FIFO is always dropped.
    assign empty     = (wp == rp);
    assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign push      = wb_en && (wb_addr != 5'd0) && !full;
    assign drop      = wb_en && (wb_addr != 5'd0) && full;
    assign fifo_full = full;
    assign busy      = (state != IDLE) || !empty;
    assign accept    = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fa[wp[AW-1:0]] <= wb_addr;
            fd[wp[AW-1:0]] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            wp        <= '0;
            rp        <= '0;
            drop_cnt  <= '0;
            line_addr <= '0;
            hex_sr    <= '0;
            name_r    <= '0;
            idx       <= '0;
        end else begin
            state <= next_state;
            if (push) wp <= wp + 1'b1;
            if (drop && drop_cnt != 16'hffff) drop_cnt <= drop_cnt + 16'd1;
            if (pop) begin
                line_addr <= fa[rp[AW-1:0]];
                hex_sr    <= fd[rp[AW-1:0]];
                rp        <= rp + 1'b1;
            end
            if (state == LOAD) begin
                name_r <= name_of(line_addr);
                idx    <= '0;
            end
            if (accept && (state == NAME || state == HEX))
                idx <= (next_state != state) ? '0 : idx + 1'b1;
            if (accept && state == HEX)
                hex_sr <= {hex_sr[DATA_W-5:0], 4'h0};
        end
    end

    always_comb begin
        next_state = state;
        tx_valid   = 1'b0;
        tx_byte    = 8'h00;
        pop        = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop        = 1'b1;
                next_state = LOAD;
            end
            LOAD: next_state = NAME;
            NAME: begin
                tx_valid = 1'b1;
                tx_byte  = (idx == '0) ? name_r[15:8] : name_r[7:0];
                if (tx_ready && idx == CW'(1)) next_state = EQ;
            end
            EQ: begin
                tx_valid = 1'b1;
                tx_byte  = "=";
                if (tx_ready) next_state = HEX;
            end
            HEX: begin
                tx_valid = 1'b1;
                tx_byte  = hex_char(hex_sr[DATA_W-1 -: 4]);
                if (tx_ready && idx == CW'(NH - 1)) next_state = EOL;
            end
            EOL: begin
                tx_valid = 1'b1;
                tx_byte  = 8'h0a;
                if (tx_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
